serial_addsub: RTL
==================

// Module: serial_addsub
// PURPOSE
//   Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop,
//   processing one operand bit per clock, LSB first.
//   Add computes s = a + b + ci with carry-out.
//   Subtract computes s = a - b - ci with borrow-out, the inverse operation.
//   Serves as the compact, multi-cycle counterpart to the parallel ripple adder
//   wherever area matters more than latency.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>= 1)
// PORTS
//   clk    input   1      rising-edge clock
//   reset  input   1      asynchronous, active-high reset
//   start  input   1      request; sampled on rising clk edge when accepted (see below)
//   sub    input   1      0 = add, 1 = subtract; captured with start
//   a      input   WIDTH  operand A; captured with start
//   b      input   WIDTH  operand B; captured with start
//   ci     input   1      carry-in (add) / borrow-in (sub); captured with start
//   busy   output  1      high while bits are being processed
//   done   output  1      one-cycle pulse: s/co just updated
//   s      output  WIDTH  result register
//   co     output  1      carry-out (add) / borrow-out (sub)
// BEHAVIOUR
//   Reset (async, any time): state=IDLE; busy=0, done=0, s=0, co=0.
//     Internal shift registers, carry flop and bit counter are cleared.
//     A reset mid-RUN discards the operation; no done is issued.
//   FSM states: IDLE, RUN, DONE.
//     IDLE: start=1 at edge -> capture a, b, sub, ci; counter=0; go RUN.
//     RUN: each edge processes bit[counter]:
//       sum bit = a0 ^ b0' ^ c, where b0' = b0 ^ sub_q.
//       c <= majority(a0, b0', c).
//       Sum bit shifts into the MSB of the result shift register; a/b shift right.
//       counter++.
//       The edge that processes bit WIDTH-1 moves to DONE and loads s and co.
//     DONE: done=1 for exactly this one cycle. Next edge:
//       start=1 -> capture new operands and go RUN (back-to-back, no idle gap);
//       otherwise -> IDLE.
//   Carry init at capture: c = ci for add, c = ~ci for subtract.
//     Subtract is implemented as a + ~b + ~ci.
//   Outputs at the end of an operation:
//     co = c_final (add) or ~c_final (sub).
//     s = low WIDTH bits of the true result, mod 2^WIDTH.
//   busy = (state == RUN). busy is 0 in IDLE and DONE.
//   s and co hold their previous values throughout RUN; they change only on
//     the edge entering DONE, and are held until the next completion or reset.
//   Latency: start sampled at edge N -> bits processed at edges N+1..N+WIDTH
//     -> done high in the cycle after edge N+WIDTH.
//     Throughput: one result per WIDTH+1 cycles.
//   start is ignored while in RUN; the operands of the ongoing operation are
//     unaffected by input changes.
//   WIDTH=1: a single RUN cycle, then DONE.
// TESTING (WIDTH=4)
//   1. Reset, then add: a=2, b=7, ci=0 -> done exactly 5 cycles after the start
//      edge; s=9, co=0; busy high for 4 cycles.
//   2. Add with carry in and carry out: 2+7+1 -> s=A, co=0; 9+3+1 -> s=D, co=0;
//      F+1+0 -> s=0, co=1.
//   3. Subtract: 2-7-0 -> s=B, co(borrow)=1; 9-3-1 -> s=5, co=0;
//      0-0-1 -> s=F, co=1.
//   4. Back-to-back: start held high in the DONE cycle with new operands ->
//      next result arrives 5 cycles later; no IDLE cycle in between.
//   5. start pulsed mid-RUN with different operands -> ignored; original result
//      returned with the original latency.
//   6. Assert reset two cycles into RUN -> busy/done/s/co go to 0 immediately
//      (asynchronously); no done follows; the next start works normally.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, one operand
// bit per clock, LSB first. Subtraction is performed as a + ~b + ~ci.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] sumSh_q, sumSh_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             sub_q, sub_d;
  logic             co_q, co_d;

  logic             bBit;
  logic             sumBit;
  logic             carryNext;
  logic [WIDTH-1:0] sumShifted;
  logic             capture;

  // Full-adder cell; b is inverted on the fly when subtracting.
  always_comb begin
    bBit       = bSh_q[0] ^ sub_q;
    sumBit     = aSh_q[0] ^ bBit ^ c_q;
    carryNext  = (aSh_q[0] & bBit) | (aSh_q[0] & c_q) | (bBit & c_q);
    sumShifted = (sumSh_q >> 1) | (WIDTH'(sumBit) << (WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sumSh_d = sumSh_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sub_d   = sub_q;
    co_d    = co_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        sumSh_d = sumShifted;
        c_d     = carryNext;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          s_d     = sumShifted;
          co_d    = sub_q ? ~carryNext : carryNext;
        end
      end
      DONE: begin
        if (start) begin
          capture = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The borrow-in enters as the complemented carry of a + ~b.
    if (capture) begin
      aSh_d = a;
      bSh_d = b;
      sub_d = sub;
      c_d   = ci ^ sub;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      sumSh_q <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sumSh_q <= sumSh_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      co_q    <= co_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;

endmodule
